// File: rtl/adder_share_pkg.sv
// Shared types and helpers for the adder-sharing arbiter.
// The FSM state encoding and the datapath width live here.
package adder_share_pkg;

  localparam int DW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Signed overflow from the operand sign bits as presented to the adder.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/prefix_adder.sv
// 16-bit Kogge-Stone parallel-prefix adder with carry-in; purely combinational.
module Prefix_Adder
  import adder_share_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          cin,
  output logic [DW-1:0] sum,
  output logic          cout
);

  localparam int LVLS = $clog2(DW);

  // Carry-in folds into bit 0 generate, so the prefix tree yields carries directly.
  always_comb begin
    logic [DW-1:0] prop_v;
    logic [DW-1:0] g_v;
    logic [DW-1:0] p_v;
    logic [DW-1:0] g_n;
    logic [DW-1:0] p_n;
    int            dist_v;
    prop_v    = a ^ b;
    g_v       = a & b;
    g_v[0]    = g_v[0] | (prop_v[0] & cin);
    p_v       = prop_v;
    g_n       = '0;
    p_n       = '0;
    dist_v    = 1;
    for (int lv = 0; lv < LVLS; lv++) begin
      dist_v = 1 << lv;
      g_n    = g_v;
      p_n    = p_v;
      for (int i = 0; i < DW; i++) begin
        if (i >= dist_v) begin
          g_n[i] = g_v[i] | (p_v[i] & g_v[(i >= dist_v) ? (i - dist_v) : 0]);
          p_n[i] = p_v[i] & p_v[(i >= dist_v) ? (i - dist_v) : 0];
        end else begin
          g_n[i] = g_v[i];
          p_n[i] = p_v[i];
        end
      end
      g_v = g_n;
      p_v = p_n;
    end
    sum  = prop_v ^ {g_v[DW-2:0], cin};
    cout = g_v[DW-1];
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int  NREQ = 4,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  // Rotating priority search; only the first hit is granted.
  always_comb begin
    logic found_v;
    int   idx_v;
    gnt     = '0;
    gnt_idx = '0;
    found_v = 1'b0;
    idx_v   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx_v = (int'(ptr) + k) % NREQ;
      if (en && !found_v && req[idx_v]) begin
        gnt[idx_v] = 1'b1;
        gnt_idx    = IW'(idx_v);
        found_v    = 1'b1;
      end else begin
        found_v = found_v;
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one Prefix_Adder among NREQ valid/ready requesters via round-robin grant.
// IDLE grants and latches operands, EXEC registers the result, DONE holds it until accepted.
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TAGW = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  input  logic [NREQ-1:0]    req_cin,
  input  logic [NREQ-1:0]    req_sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_sum,
  output logic               out_cout,
  output logic               out_ovf,
  output logic [TAGW-1:0]    out_tag
);

  state_e          state_q, state_d;
  logic [TAGW-1:0] rr_ptr_q, rr_ptr_d;
  logic [DW-1:0]   a_q, a_d, b_q, b_d;
  logic            cin_q, cin_d, sub_q, sub_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_sum_q, out_sum_d;
  logic            out_cout_q, out_cout_d, out_ovf_q, out_ovf_d;
  logic [TAGW-1:0] out_tag_q, out_tag_d;

  logic [NREQ-1:0] gnt_s;
  logic [TAGW-1:0] gnt_idx_s;
  logic            arb_en_s;
  logic [DW-1:0]   add_b_s, sum_s;
  logic            add_cin_s, cout_s;

  // No grant while in reset, so ready stays low until the FSM is live.
  assign arb_en_s  = (state_q == IDLE) && rst_n;
  assign req_ready = gnt_s;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .en      (arb_en_s),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  assign add_b_s   = sub_q ? ~b_q : b_q;
  assign add_cin_s = sub_q ? 1'b1 : cin_q;

  Prefix_Adder u_add (
    .a    (a_q),
    .b    (add_b_s),
    .cin  (add_cin_s),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // Next-state and register-enable logic for the grant/execute/hold sequence.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    sub_d       = sub_q;
    tag_d       = tag_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    out_ovf_d   = out_ovf_q;
    out_tag_d   = out_tag_q;
    case (state_q)
      IDLE: begin
        if (|gnt_s) begin
          a_d   = req_a[int'(gnt_idx_s)*DW +: DW];
          b_d   = req_b[int'(gnt_idx_s)*DW +: DW];
          cin_d = req_cin[gnt_idx_s];
          sub_d = req_sub[gnt_idx_s];
          tag_d = gnt_idx_s;
          if (gnt_idx_s == TAGW'(NREQ - 1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = gnt_idx_s + TAGW'(1);
          end
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        out_sum_d   = sum_s;
        out_cout_d  = cout_s;
        out_ovf_d   = add_ovf(a_q[DW-1], add_b_s[DW-1], sum_s[DW-1]);
        out_tag_d   = tag_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State, operand and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      sub_q       <= 1'b0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      sub_q       <= sub_d;
      tag_q       <= tag_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: directed vector table, fairness, backpressure,
// mid-operation reset and a random phase checked against an arithmetic reference model.
module tb_adder_share_arbiter;

  localparam int NREQ = 4;
  localparam int TAGW = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid, req_ready, req_cin, req_sub;
  logic [NREQ*16-1:0]   req_a, req_b;
  logic                 out_valid, out_ready, out_cout, out_ovf;
  logic [15:0]          out_sum;
  logic [TAGW-1:0]      out_tag;

  always #5 clk = ~clk;

  adder_share_arbiter #(.NREQ(NREQ), .TAGW(TAGW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_sub(req_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_tag(out_tag)
  );

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic [1:0]  tag;
  } res_t;

  typedef struct {
    int          port;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  int   checks = 0;
  int   fails  = 0;
  res_t exp_q[$];
  res_t last_res;
  int   grant_log[$];
  int   ptr_m, stage_m, n_acc;
  bit   rand_mode, refill_mode;

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub, input int tag);
    res_t r;
    int ua, ub, sa, sb, full, s;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      full   = ua - ub;
      s      = sa - sb;
      r.cout = (ua >= ub);
    end else begin
      full   = ua + ub + int'(cin);
      s      = sa + sb + int'(cin);
      r.cout = (full > 65535);
    end
    r.sum = 16'(full);
    r.ovf = (s > 32767) || (s < -32768);
    r.tag = 2'(tag);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic post(input int p, input logic [15:0] a, input logic [15:0] b,
                      input logic c, input logic s);
    req_a[16*p +: 16] = a;
    req_b[16*p +: 16] = b;
    req_cin[p]        = c;
    req_sub[p]        = s;
    req_valid[p]      = 1'b1;
  endtask

  task automatic post_rand(input int p);
    post(p, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // One clock: check outputs at negedge against the model, then advance it.
  task automatic step();
    int          g;
    logic [3:0]  exp_rdy;
    bit          acc;
    res_t        e;
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(stage_m == 2));
    if (stage_m == 2 && exp_q.size() > 0) begin
      e = exp_q[0];
      chk("out_sum", 32'(out_sum), 32'(e.sum));
      chk("out_cout", 32'(out_cout), 32'(e.cout));
      chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
      chk("out_tag", 32'(out_tag), 32'(e.tag));
    end
    g       = -1;
    exp_rdy = '0;
    if (stage_m == 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (ptr_m + k) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    acc = (stage_m == 2) && out_ready;
    if (stage_m == 1) begin
      stage_m = 2;
    end else if (acc) begin
      stage_m = 0;
    end else if (g >= 0) begin
      stage_m = 1;
      ptr_m   = (g + 1) % NREQ;
      exp_q.push_back(model(req_a[16*g +: 16], req_b[16*g +: 16], req_cin[g], req_sub[g], g));
      grant_log.push_back(g);
    end
    @(posedge clk);
    #1;
    if (g >= 0) begin
      req_valid[g] = 1'b0;
      if (refill_mode) post_rand(g);
    end
    if (acc) begin
      last_res = exp_q.pop_front();
      n_acc++;
    end
    if (rand_mode) begin
      for (int p = 0; p < NREQ; p++)
        if (!req_valid[p] && $urandom_range(0, 3) == 0) post_rand(p);
      out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_acc(input int target, input string nm);
    int n = 0;
    while (n_acc < target && n < 60) begin
      step();
      n++;
    end
    chk(nm, 32'(n_acc), 32'(target));
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((req_valid != '0 || stage_m != 0) && n < 200) begin
      step();
      n++;
    end
    chk("drain_idle", 32'(req_valid != '0 || stage_m != 0), 32'(0));
  endtask

  task automatic model_reset();
    ptr_m   = 0;
    stage_m = 0;
    exp_q.delete();
  endtask

  vec_t tbl[9];

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int start, sz;
    tbl[0] = '{0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[1] = '{2, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[2] = '{2, 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    tbl[3] = '{1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[4] = '{3, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[5] = '{1, 16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0};
    tbl[6] = '{3, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[7] = '{0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[8] = '{2, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};

    rand_mode   = 1'b0;
    refill_mode = 1'b0;
    n_acc       = 0;
    rst_n       = 1'b1;
    out_ready   = 1'b0;
    req_valid   = '0;
    req_cin     = '0;
    req_sub     = '0;
    req_a       = '0;
    req_b       = '0;
    #2 rst_n = 1'b0;

    // Reset held with random inputs: nothing granted, nothing valid.
    repeat (4) begin
      @(posedge clk);
      #1;
      req_valid = 4'($urandom);
      req_a     = {$urandom, $urandom};
      req_b     = {$urandom, $urandom};
      req_cin   = 4'($urandom);
      req_sub   = 4'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_req_ready", 32'(req_ready), 32'(0));
      chk("rst_out_sum", 32'(out_sum), 32'(0));
    end
    req_valid = '0;
    post(2, 16'h0100, 16'h0023, 1'b1, 1'b0);
    post(3, 16'h0050, 16'h0060, 1'b0, 1'b1);
    out_ready = 1'b1;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_acc(2, "reset_release_acc");
    chk("first_grant", 32'(grant_log[0]), 32'(2));
    drain();

    // Directed vector table.
    foreach (tbl[i]) begin
      post(tbl[i].port, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub);
      wait_acc(n_acc + 1, "vec_acc");
      chk("vec_sum", 32'(last_res.sum), 32'(tbl[i].sum));
      chk("vec_cout", 32'(last_res.cout), 32'(tbl[i].cout));
      chk("vec_ovf", 32'(last_res.ovf), 32'(tbl[i].ovf));
      chk("vec_tag", 32'(last_res.tag), 32'(tbl[i].port));
    end

    // Fairness with all requesters continuously valid.
    grant_log.delete();
    start = ptr_m;
    refill_mode = 1'b1;
    for (int p = 0; p < NREQ; p++) post_rand(p);
    wait_acc(n_acc + 8, "fair_acc");
    refill_mode = 1'b0;
    drain();
    for (int k = 0; k < 8; k++)
      chk("fair_order", 32'(grant_log[k]), 32'((start + k) % NREQ));

    // Backpressure: result held ten cycles, no grants meanwhile.
    out_ready = 1'b0;
    post(1, 16'hABCD, 16'h1234, 1'b1, 1'b0);
    begin
      int n = 0;
      while (stage_m != 2 && n < 20) begin step(); n++; end
    end
    chk("bp_reached_done", 32'(stage_m), 32'(2));
    post(2, 16'h4000, 16'hC000, 1'b0, 1'b1);
    sz = grant_log.size();
    repeat (10) step();
    chk("bp_no_grant", 32'(grant_log.size()), 32'(sz));
    out_ready = 1'b1;
    step();
    step();
    chk("bp_next_grant", 32'(grant_log.size()), 32'(sz + 1));
    drain();

    // Reset during EXEC discards the operation and rewinds the pointer.
    post(1, 16'h0F0F, 16'h0101, 1'b0, 1'b0);
    begin
      int n = 0;
      while (stage_m != 1 && n < 20) begin step(); n++; end
    end
    post(1, 16'h0F0F, 16'h0101, 1'b0, 1'b0);
    post(3, 16'h2222, 16'h1111, 1'b0, 1'b1);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_out_valid", 32'(out_valid), 32'(0));
      chk("midrst_req_ready", 32'(req_ready), 32'(0));
    end
    model_reset();
    sz = grant_log.size();
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_acc(n_acc + 2, "midrst_acc");
    if (grant_log.size() >= sz + 2) begin
      chk("midrst_regrant", 32'(grant_log[sz]), 32'(1));
      chk("midrst_second", 32'(grant_log[sz+1]), 32'(3));
    end else begin
      chk("midrst_grants", 32'(grant_log.size()), 32'(sz + 2));
    end
    drain();

    // Random traffic and random backpressure.
    rand_mode = 1'b1;
    repeat (600) step();
    rand_mode = 1'b0;
    drain();
    chk("final_queue_empty", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
